// File: rtl/seq_det_pkg.sv
// Shared definitions for the programmable serial sequence detector:
// progress-width helper, overlap-mode encoding and pattern-length clamp.
package seq_det_pkg;

  localparam logic MODE_NOVL = 1'b0;
  localparam logic MODE_OVL  = 1'b1;

  function automatic int prog_w(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

  // Zero or oversize lengths fall back to the full pattern width.
  function automatic int clamp_len(input int len, input int pat_w);
    return (len == 0 || len > pat_w) ? pat_w : len;
  endfunction

endpackage

// File: rtl/seq_det_prefix.sv
// Combinational finder: largest k (k <= fill_next, k < len or k <= len) such that
// the newest k history bits equal the first k pattern bits.
module seq_det_prefix
  import seq_det_pkg::*;
#(
  parameter int PAT_W = 6
) (
  input  logic [PAT_W-1:0]         hist_next,
  input  logic [PAT_W-1:0]         pat,
  input  logic [prog_w(PAT_W)-1:0] len,
  input  logic [prog_w(PAT_W)-1:0] fill_next,
  input  logic                     exclude_full,
  output logic [prog_w(PAT_W)-1:0] k
);

  localparam int LW = prog_w(PAT_W);

  logic [PAT_W-1:0] mask_c;

  // Ascending scan, so the last qualifying candidate is the longest one.
  always_comb begin
    k      = '0;
    mask_c = '0;
    for (int c = 1; c <= PAT_W; c++) begin
      if ((c < int'(len) || (!exclude_full && c == int'(len))) && c <= int'(fill_next)) begin
        mask_c = {PAT_W{1'b1}} >> (PAT_W - c);
        if ((hist_next & mask_c) == ((pat >> (int'(len) - c)) & mask_c))
          k = LW'(c);
      end
    end
  end

endmodule

// File: rtl/seq_det_param.sv
// Runtime-programmable serial sequence detector with overlap control.
// Optional saturating match counter enabled by `define SEQ_DET_CNT_EN.
module seq_det_param
  import seq_det_pkg::*;
#(
  parameter int               PAT_W   = 6,
  parameter int               CNT_W   = 8,
  parameter logic [PAT_W-1:0] PAT_RST = 6'b101011,
  parameter int               LEN_RST = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in,
  input  logic                     in_valid,
  input  logic                     overlap,
  input  logic                     cfg_load,
  input  logic [PAT_W-1:0]         cfg_pat,
  input  logic [prog_w(PAT_W)-1:0] cfg_len,
  input  logic                     cnt_clr,
  output logic                     out,
  output logic [prog_w(PAT_W)-1:0] state,
  output logic [CNT_W-1:0]         match_cnt
);

  localparam int LW = prog_w(PAT_W);

  logic [PAT_W-1:0] hist, hist_next, pat_q, len_mask;
  logic [LW-1:0]    len_q, fill, fill_next, k;
  logic             match, match_evt;

  assign hist_next = {hist[PAT_W-2:0], in};
  assign fill_next = (fill == LW'(PAT_W)) ? fill : fill + 1'b1;
  assign len_mask  = {PAT_W{1'b1}} >> (PAT_W - int'(len_q));
  assign match     = (fill_next >= len_q) && (((hist_next ^ pat_q) & len_mask) == '0);
  assign match_evt = in_valid && !cfg_load && match;

  seq_det_prefix #(.PAT_W(PAT_W)) u_prefix (
    .hist_next    (hist_next),
    .pat          (pat_q),
    .len          (len_q),
    .fill_next    (fill_next),
    .exclude_full (1'b1),
    .k            (k)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_q <= PAT_RST;
      len_q <= LW'(clamp_len(LEN_RST, PAT_W));
      hist  <= '0;
      fill  <= '0;
      state <= '0;
      out   <= 1'b0;
    end else if (cfg_load) begin
      pat_q <= cfg_pat;
      len_q <= LW'(clamp_len(int'(cfg_len), PAT_W));
      hist  <= '0;
      fill  <= '0;
      state <= '0;
      out   <= 1'b0;
    end else if (in_valid) begin
      hist <= hist_next;
      out  <= match;
      // Non-overlapping: emptying fill keeps matched bits out of the next search.
      if (match && overlap == MODE_NOVL) begin
        state <= '0;
        fill  <= '0;
      end else begin
        state <= k;
        fill  <= fill_next;
      end
    end else begin
      out <= 1'b0;
    end
  end

`ifdef SEQ_DET_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      match_cnt <= '0;
    else if (cnt_clr)
      match_cnt <= match_evt ? CNT_W'(1) : '0;
    else if (match_evt && match_cnt != '1)
      match_cnt <= match_cnt + 1'b1;
  end
`else
  logic unused_cnt;
  assign unused_cnt = cnt_clr ^ match_evt;
  assign match_cnt  = '0;
`endif

endmodule

// File: tb/tb_seq_det_param.sv
// Directed bench for seq_det_param; counter expectations follow SEQ_DET_CNT_EN.
module tb_seq_det_param;

`ifdef SEQ_DET_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in = 1'b0;
  logic       in_valid = 1'b0;
  logic       overlap = 1'b0;
  logic       cfg_load = 1'b0;
  logic [5:0] cfg_pat = '0;
  logic [2:0] cfg_len = '0;
  logic       cnt_clr = 1'b0;
  logic       out;
  logic [2:0] state;
  logic [1:0] match_cnt;

  int total = 0;
  int bad   = 0;

  seq_det_param #(.CNT_W(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in        (in),
    .in_valid  (in_valid),
    .overlap   (overlap),
    .cfg_load  (cfg_load),
    .cfg_pat   (cfg_pat),
    .cfg_len   (cfg_len),
    .cnt_clr   (cnt_clr),
    .out       (out),
    .state     (state),
    .match_cnt (match_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] ec(input int v);
    return CNT_EN ? 2'(v) : 2'd0;
  endfunction

  task automatic send_bit(input logic b);
    @(negedge clk);
    in = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    in = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic load_cfg(input logic [5:0] p, input logic [2:0] l);
    @(negedge clk);
    cfg_load = 1'b1;
    cfg_pat  = p;
    cfg_len  = l;
    @(posedge clk);
    #1;
    cfg_load = 1'b0;
  endtask

  task automatic test_reset();
    logic [5:0] bits = 6'b101011;
    int st[6] = '{1, 2, 3, 4, 5, 0};
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    total += 3;
    if (out !== 1'b0) begin bad++; $display("FAIL reset_out got=%b want=0", out); end
    if (state !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", state); end
    if (match_cnt !== 2'd0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", match_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    overlap = 1'b0;
    for (int i = 0; i < 6; i++) begin
      send_bit(bits[5-i]);
      total += 2;
      if (out !== (i == 5)) begin bad++; $display("FAIL dflt_out bit=%0d got=%b want=%b", i, out, (i == 5)); end
      if (state !== 3'(st[i])) begin bad++; $display("FAIL dflt_state bit=%0d got=%0d want=%0d", i, state, st[i]); end
    end
    total++;
    if (match_cnt !== ec(1)) begin bad++; $display("FAIL dflt_cnt got=%0d want=%0d", match_cnt, ec(1)); end
    idle_cycle();
    total++;
    if (out !== 1'b0) begin bad++; $display("FAIL dflt_pulse_width got=%b want=0", out); end
  endtask

  task automatic test_overlap_1010();
    logic [5:0] bits = 6'b101010;
    int st_ovl[6] = '{1, 2, 3, 2, 3, 2};
    int st_nov[6] = '{1, 2, 3, 0, 1, 2};
    for (int m = 1; m >= 0; m--) begin
      apply_reset();
      load_cfg(6'b001010, 3'd4);
      overlap = logic'(m);
      for (int i = 0; i < 6; i++) begin
        send_bit(bits[5-i]);
        total += 2;
        if (m == 1) begin
          if (out !== (i == 3 || i == 5)) begin bad++; $display("FAIL ovl1010_out bit=%0d got=%b", i, out); end
          if (state !== 3'(st_ovl[i])) begin bad++; $display("FAIL ovl1010_state bit=%0d got=%0d want=%0d", i, state, st_ovl[i]); end
        end else begin
          if (out !== (i == 3)) begin bad++; $display("FAIL nov1010_out bit=%0d got=%b", i, out); end
          if (state !== 3'(st_nov[i])) begin bad++; $display("FAIL nov1010_state bit=%0d got=%0d want=%0d", i, state, st_nov[i]); end
        end
      end
      total++;
      if (match_cnt !== ec(m == 1 ? 2 : 1)) begin
        bad++; $display("FAIL cnt1010 mode=%0d got=%0d want=%0d", m, match_cnt, ec(m == 1 ? 2 : 1));
      end
    end
  endtask

  task automatic test_back_to_back();
    int st[5] = '{1, 2, 2, 2, 2};
    apply_reset();
    load_cfg(6'b000111, 3'd3);
    overlap = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send_bit(1'b1);
      total += 2;
      if (out !== (i >= 2)) begin bad++; $display("FAIL b2b_out bit=%0d got=%b want=%b", i, out, (i >= 2)); end
      if (state !== 3'(st[i])) begin bad++; $display("FAIL b2b_state bit=%0d got=%0d want=%0d", i, state, st[i]); end
    end
  endtask

  task automatic test_gap();
    logic [5:0] bits = 6'b101011;
    int st[6] = '{1, 2, 3, 4, 5, 0};
    apply_reset();
    overlap = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i == 3) begin
        for (int g = 0; g < 3; g++) begin
          idle_cycle();
          total += 2;
          if (state !== 3'd3) begin bad++; $display("FAIL gap_state cyc=%0d got=%0d want=3", g, state); end
          if (out !== 1'b0) begin bad++; $display("FAIL gap_out cyc=%0d got=%b want=0", g, out); end
        end
      end
      send_bit(bits[5-i]);
      total += 2;
      if (out !== (i == 5)) begin bad++; $display("FAIL gap_match bit=%0d got=%b", i, out); end
      if (state !== 3'(st[i])) begin bad++; $display("FAIL gap_prog bit=%0d got=%0d want=%0d", i, state, st[i]); end
    end
  endtask

  task automatic test_cfg_priority();
    logic [3:0] bits = 4'b1010;
    apply_reset();
    overlap = 1'b0;
    for (int i = 0; i < 4; i++) send_bit(bits[3-i]);
    total++;
    if (state !== 3'd4) begin bad++; $display("FAIL prio_pre_state got=%0d want=4", state); end
    @(negedge clk);
    cfg_load = 1'b1; cfg_pat = 6'b000011; cfg_len = 3'd2;
    in = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    #1;
    cfg_load = 1'b0; in_valid = 1'b0;
    total += 2;
    if (state !== 3'd0) begin bad++; $display("FAIL prio_load_state got=%0d want=0", state); end
    if (out !== 1'b0) begin bad++; $display("FAIL prio_load_out got=%b want=0", out); end
    send_bit(1'b1);
    total += 2;
    if (out !== 1'b0) begin bad++; $display("FAIL prio_first_out got=%b want=0", out); end
    if (state !== 3'd1) begin bad++; $display("FAIL prio_first_state got=%0d want=1", state); end
    send_bit(1'b1);
    total += 2;
    if (out !== 1'b1) begin bad++; $display("FAIL prio_match_out got=%b want=1", out); end
    if (state !== 3'd0) begin bad++; $display("FAIL prio_match_state got=%0d want=0", state); end
  endtask

  task automatic test_len_edges();
    logic [5:0] bits = 6'b110011;
    logic [2:0] one = 3'b101;
    apply_reset();
    overlap = 1'b0;
    load_cfg(6'b110011, 3'd0);
    for (int i = 0; i < 6; i++) begin
      send_bit(bits[5-i]);
      total++;
      if (out !== (i == 5)) begin bad++; $display("FAIL clamp_out bit=%0d got=%b", i, out); end
    end
    load_cfg(6'b000001, 3'd1);
    overlap = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send_bit(one[2-i]);
      total += 2;
      if (out !== one[2-i]) begin bad++; $display("FAIL len1_out bit=%0d got=%b want=%b", i, out, one[2-i]); end
      if (state !== 3'd0) begin bad++; $display("FAIL len1_state bit=%0d got=%0d want=0", i, state); end
    end
  endtask

  task automatic test_reset_mid();
    logic [2:0] pre = 3'b101;
    logic [2:0] post = 3'b011;
    int st[3] = '{0, 1, 1};
    apply_reset();
    overlap = 1'b0;
    for (int i = 0; i < 3; i++) send_bit(pre[2-i]);
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      send_bit(post[2-i]);
      total += 2;
      if (out !== 1'b0) begin bad++; $display("FAIL midrst_out bit=%0d got=%b want=0", i, out); end
      if (state !== 3'(st[i])) begin bad++; $display("FAIL midrst_state bit=%0d got=%0d want=%0d", i, state, st[i]); end
    end
  endtask

  task automatic test_saturation();
    int cnt_exp[8] = '{0, 0, 1, 2, 3, 3, 3, 3};
    apply_reset();
    load_cfg(6'b000111, 3'd3);
    overlap = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send_bit(1'b1);
      total++;
      if (match_cnt !== ec(cnt_exp[i])) begin
        bad++; $display("FAIL sat_cnt bit=%0d got=%0d want=%0d", i, match_cnt, ec(cnt_exp[i]));
      end
    end
    cnt_clr = 1'b1;
    send_bit(1'b1);
    total += 2;
    if (match_cnt !== ec(1)) begin bad++; $display("FAIL clr_on_match got=%0d want=%0d", match_cnt, ec(1)); end
    if (out !== 1'b1) begin bad++; $display("FAIL clr_match_out got=%b want=1", out); end
    idle_cycle();
    cnt_clr = 1'b0;
    total++;
    if (match_cnt !== 2'd0) begin bad++; $display("FAIL clr_alone got=%0d want=0", match_cnt); end
  endtask

  initial begin
    test_reset();
    test_overlap_1010();
    test_back_to_back();
    test_gap();
    test_cfg_priority();
    test_len_edges();
    test_reset_mid();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_det_param.md
# seq_det_param

Parametrised serial sequence detector with a runtime-programmable pattern. It scans a single-bit input stream qualified by a valid strobe, supports overlapping and non-overlapping match modes, and reports per-bit match progress. It emits a one-cycle match pulse and keeps an optional saturating match counter. It replaces fixed-pattern detector FSMs in the serial front-end and sits directly after the bit deserialiser.

## Interface
Parameters:
- PAT_W, 6: maximum pattern length in bits (≥2).
- CNT_W, 8: match counter width.
- PAT_RST, 6'b101011: pattern loaded at reset; PAT_W bits, first-received bit at MSB of the active length.
- LEN_RST, 6: pattern length loaded at reset.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in  in  1  serial data bit.
- in_valid  in  1  `in` is sampled only when high.
- overlap  in  1  1 = overlapping matches, 0 = non-overlapping; sampled every valid cycle.
- cfg_load  in  1  load `cfg_pat`/`cfg_len`; restarts detection.
- cfg_pat  in  PAT_W  new pattern; bit `cfg_len-1` is received first, bit 0 last.
- cfg_len  in  $clog2(PAT_W+1)  new pattern length.
- cnt_clr  in  1  synchronous clear of `match_cnt`.
- out  out  1  match pulse.
- state  out  $clog2(PAT_W+1)  current progress: count of pattern-prefix bits matched.
- match_cnt  out  CNT_W  saturating match count.

## Operation
- Registers:
  - `hist`, PAT_W bits: newest bit is `hist[0]`; shifts left on each valid bit.
  - `fill`: number of valid history bits, saturates at PAT_W.
  - Pattern and length.
  - `state`, `out`, `match_cnt`.
- Valid cycle (`in_valid=1`, `cfg_load=0`):
  - next history is `{hist[PAT_W-2:0], in}`.
  - Match when `fill_next ≥ len` and `hist_next[len-1:0] == pat[len-1:0]`.
- On match:
  - `out` is 1 next cycle.
  - overlap=1: `state` = longest proper prefix of pattern (length < len) that equals a suffix of `hist_next`. `fill` is kept.
  - overlap=0: `state`=0 and `fill`=0; no bits of the match are reused.
- No match: `state` = largest k < len with k ≤ `fill_next` and `hist_next[k-1:0] == pat[len-1:len-k]`.
- `in_valid=0`: history, `fill` and `state` hold; `out` drops to 0.
- `cfg_load=1`:
  - Latches the pattern and length.
  - Clears `hist`, `fill`, `state`, `out`.
  - Takes priority over a same-cycle valid bit; that bit is discarded.
  - `match_cnt` is untouched.
- `cfg_len` = 0 or > PAT_W is clamped to PAT_W.
- `cfg_len` = 1 matches on every bit equal to `pat[0]`; `state` is always 0.
- `match_cnt` increments by 1 per match and saturates at all-ones.
- `cnt_clr` together with a match gives `match_cnt`=1. `cnt_clr` alone gives 0.
- Reset values:
  - pattern=PAT_RST, length=LEN_RST (clamped).
  - hist=0, fill=0, state=0, out=0, match_cnt=0.
- Reset mid-stream discards partial progress; detection restarts from the next valid bit.

## Timing
- Latency: `out` is high for exactly one cycle, the cycle after the edge that samples the final pattern bit.
- Back-to-back matches in overlap mode give `out` high on consecutive cycles.
- `state` and `match_cnt` update on the same edge as `out`.
- `cfg_load` takes effect at the next edge. The first bit that counts is the one valid on the edge after the load.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `SEQ_DET_CNT_EN`:
  - Defined: `match_cnt` register and `cnt_clr` logic are present as described.
  - Undefined: `match_cnt` is tied to 0, `cnt_clr` is ignored, and no counter flops are generated.
- `out` and `state` behave identically in both builds.

## Structure
- Shared package `seq_det_pkg`:
  - progress-width localparam function (`$clog2(PAT_W+1)` helper).
  - overlap-mode encoding constants (`MODE_NOVL=0`, `MODE_OVL=1`).
  - length-clamp function.
- One sub-module, `seq_det_prefix`: combinational longest-prefix/suffix finder.
  - Inputs: `hist_next`, pattern, length, `fill_next`, `exclude_full`.
  - Output: k.
  - Instantiated once. The top holds all sequential logic.

## Test plan
- Reset defaults (101011, len 6), stream 1,0,1,0,1,1 valid on consecutive edges:
  - `out`=1 for one cycle after the 6th edge; `match_cnt`=1.
  - `state` sequence is 1,2,3,4,5,0 (overlap=0).
- Load pattern 1010, len 4; stream 1,0,1,0,1,0:
  - overlap=1: `out` pulses after bits 4 and 6; `state` after bit 4 is 2; `match_cnt`=2.
  - overlap=0: one pulse only, after bit 4; `match_cnt`=1.
- Pattern 111, overlap=1, stream of five 1s: `out` high for 3 consecutive cycles (after bits 3, 4, 5).
- Stream 1,0,1,0,1 with `in_valid` low for 3 cycles between bits 3 and 4, then 1:
  - Match pulse is still produced after the final 1.
  - `state` holds at 3 during the gap.
- Pattern partially matched (`state`=4), then `cfg_load` of 11, len 2, together with a valid `in`=1: that bit is discarded; `state`=0; next bits 1,1 give a pulse.
- With `SEQ_DET_CNT_EN`, CNT_W=2, repeat the overlap 111 stream for 6 matches:
  - `match_cnt` saturates at 3.
  - `cnt_clr` asserted on a match edge gives 1.
  - Without the macro, `match_cnt` stays 0 throughout.
